// File: rtl/plab2_proc_regfile_writeback_pkg.sv
// Shared definitions for the register-file writeback slice: regfile geometry,
// source identifiers and the queued-write entry format.
package plab2_proc_regfile_writeback_pkg;

    localparam int PLAB2_RF_NREGS = 32;
    localparam int PLAB2_RF_ABITS = 5;
    localparam int PLAB2_DATA_W   = 32;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_LONG = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic [PLAB2_RF_ABITS-1:0] addr;
        logic [PLAB2_DATA_W-1:0]   data;
    } wb_entry_t;

    function automatic logic [PLAB2_RF_NREGS-1:0] addr_onehot(input logic [PLAB2_RF_ABITS-1:0] a);
        addr_onehot    = '0;
        addr_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/plab2_proc_wb_queue.sv
// Per-source writeback FIFO. Writes to r0 are accepted but never stored, and
// every slot exposes its valid bit and address for pending-write mask building.
module plab2_proc_wb_queue
    import plab2_proc_regfile_writeback_pkg::*;
#(
    parameter int p_depth = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        i_enq_val,
    output logic                                        o_enq_rdy,
    input  wb_entry_t                                   i_enq_ent,
    output logic                                        o_deq_val,
    input  logic                                        i_deq_pop,
    output wb_entry_t                                   o_deq_ent,
    output logic [p_depth-1:0]                          o_ent_val,
    output logic [p_depth-1:0][PLAB2_RF_ABITS-1:0]      o_ent_addr
);

    localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [p_depth-1:0] r_val;
    wb_entry_t          r_ent [p_depth];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(p_depth - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = p + 1'b1;
        end
    endfunction

    // Ready depends only on registered occupancy, so a pop never frees room
    // for a push in the same cycle.
    assign o_enq_rdy = ~&r_val;
    assign o_deq_val = r_val[r_head];
    assign o_deq_ent = r_ent[r_head];
    assign o_ent_val = r_val;
    assign w_push    = i_enq_val && o_enq_rdy && (i_enq_ent.addr != '0);
    assign w_pop     = i_deq_pop && o_deq_val;

    always_comb begin
        o_ent_addr = '0;
        for (int i = 0; i < p_depth; i++) begin
            o_ent_addr[i] = r_ent[i].addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_pop) begin
                r_val[r_head] <= 1'b0;
                r_head        <= ptr_next(r_head);
            end
            if (w_push) begin
                r_val[r_tail] <= 1'b1;
                r_tail        <= ptr_next(r_tail);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent[r_tail] <= i_enq_ent;
        end
    end

endmodule

// File: rtl/plab2_proc_regfile_writeback.sv
// Write side of the r0-hardwired register file: buffers two result sources,
// arbitrates them onto one write port and publishes a pending-write mask.
module plab2_proc_regfile_writeback
    import plab2_proc_regfile_writeback_pkg::*;
#(
    parameter int p_depth  = 2,
    parameter int p_starve = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      domain,
    input  logic                      s0_val,
    output logic                      s0_rdy,
    input  logic [PLAB2_RF_ABITS-1:0] s0_addr,
    input  logic [PLAB2_DATA_W-1:0]   s0_data,
    input  logic                      s1_val,
    output logic                      s1_rdy,
    input  logic [PLAB2_RF_ABITS-1:0] s1_addr,
    input  logic [PLAB2_DATA_W-1:0]   s1_data,
    output logic                      rf_wen,
    output logic [PLAB2_RF_ABITS-1:0] rf_waddr,
    output logic [PLAB2_DATA_W-1:0]   rf_wdata,
    output logic [PLAB2_RF_NREGS-1:0] pend_mask,
    output logic                      busy
);

    localparam int SW = $clog2(p_starve + 1);

    logic                                   r_live;
    logic [SW-1:0]                          r_starve;
    logic                                   r_wen;
    logic [PLAB2_RF_ABITS-1:0]              r_waddr;
    logic [PLAB2_DATA_W-1:0]                r_wdata;

    logic                                   w_q0_rdy, w_q1_rdy;
    logic                                   w_q0_val, w_q1_val;
    wb_entry_t                              w_q0_ent, w_q1_ent;
    logic [p_depth-1:0]                     w_q0_ev, w_q1_ev;
    logic [p_depth-1:0][PLAB2_RF_ABITS-1:0] w_q0_ea, w_q1_ea;
    logic                                   w_win;
    wb_src_t                                w_sel;
    wb_entry_t                              w_win_ent;
    logic                                   w_pop0, w_pop1;
    logic [PLAB2_RF_NREGS-1:0]              w_mask;

    // Valid/ready: a source transfers on a rising edge where its val and rdy
    // are both high; rdy is held low until the first edge after reset release.
    assign s0_rdy = r_live && w_q0_rdy;
    assign s1_rdy = r_live && w_q1_rdy;

    plab2_proc_wb_queue #(.p_depth(p_depth)) u_q0 (
        .clk        (clk),
        .reset      (reset),
        .i_enq_val  (s0_val && r_live),
        .o_enq_rdy  (w_q0_rdy),
        .i_enq_ent  ({s0_addr, s0_data}),
        .o_deq_val  (w_q0_val),
        .i_deq_pop  (w_pop0),
        .o_deq_ent  (w_q0_ent),
        .o_ent_val  (w_q0_ev),
        .o_ent_addr (w_q0_ea)
    );

    plab2_proc_wb_queue #(.p_depth(p_depth)) u_q1 (
        .clk        (clk),
        .reset      (reset),
        .i_enq_val  (s1_val && r_live),
        .o_enq_rdy  (w_q1_rdy),
        .i_enq_ent  ({s1_addr, s1_data}),
        .o_deq_val  (w_q1_val),
        .i_deq_pop  (w_pop1),
        .o_deq_ent  (w_q1_ent),
        .o_ent_val  (w_q1_ev),
        .o_ent_addr (w_q1_ea)
    );

    // The pipeline source has priority unless the long-latency source has lost
    // p_starve times in a row.
    always_comb begin
        w_win = 1'b0;
        w_sel = WB_SRC_PIPE;
        if (w_q1_val && (!w_q0_val || r_starve == SW'(p_starve))) begin
            w_win = 1'b1;
            w_sel = WB_SRC_LONG;
        end else if (w_q0_val) begin
            w_win = 1'b1;
            w_sel = WB_SRC_PIPE;
        end
    end

    assign w_pop0    = w_win && (w_sel == WB_SRC_PIPE);
    assign w_pop1    = w_win && (w_sel == WB_SRC_LONG);
    assign w_win_ent = (w_sel == WB_SRC_LONG) ? w_q1_ent : w_q0_ent;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live   <= 1'b0;
            r_starve <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_live <= 1'b1;
            if (!w_q1_val || w_pop1) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + 1'b1;
            end
            r_wen <= w_win;
            if (w_win) begin
                r_waddr <= w_win_ent.addr;
                r_wdata <= w_win_ent.data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < p_depth; i++) begin
            if (w_q0_ev[i]) w_mask = w_mask | addr_onehot(w_q0_ea[i]);
            if (w_q1_ev[i]) w_mask = w_mask | addr_onehot(w_q1_ea[i]);
        end
        if (r_wen) w_mask = w_mask | addr_onehot(r_waddr);
    end

    assign rf_wen    = r_wen;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign pend_mask = w_mask;
    assign busy      = |w_mask;

    // All labelled data in flight belongs to one domain; it may not switch
    // underneath queued writes.
    a_domain_stable : assert property (@(posedge clk) disable iff (!reset) busy |-> $stable(domain));

endmodule

// File: tb/tb_plab2_proc_regfile_writeback.sv
// Directed bench for the regfile writeback block: a queue-level behavioural
// model checked every cycle, plus literal expectations for each scenario.
module tb_plab2_proc_regfile_writeback;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        domain;
    logic        s0_val, s1_val;
    logic        s0_rdy, s1_rdy;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model state: plain queues of pending writes per source.
    wr_t         m_q0[$];
    wr_t         m_q1[$];
    int          m_starve = 0;
    bit          m_live   = 1'b0;
    bit          m_wen    = 1'b0;
    logic [4:0]  m_waddr  = '0;
    logic [31:0] m_wdata  = '0;
    bit          m_acc0, m_acc1;
    int          m_pick;
    wr_t         m_w;

    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    plab2_proc_regfile_writeback #(.p_depth(DEPTH), .p_starve(STARVE)) dut (
        .clk       (clk),
        .reset     (reset),
        .domain    (domain),
        .s0_val    (s0_val),
        .s0_rdy    (s0_rdy),
        .s0_addr   (s0_addr),
        .s0_data   (s0_data),
        .s1_val    (s1_val),
        .s1_rdy    (s1_rdy),
        .s1_addr   (s1_addr),
        .s1_data   (s1_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: one step per clock edge from the pre-edge state.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_q0.delete();
            m_q1.delete();
            m_starve = 0;
            m_live   = 1'b0;
            m_wen    = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
        end else begin
            m_acc0 = s0_val && m_live && (m_q0.size() < DEPTH);
            m_acc1 = s1_val && m_live && (m_q1.size() < DEPTH);
            m_pick = -1;
            if (m_q1.size() != 0 && (m_q0.size() == 0 || m_starve >= STARVE)) m_pick = 1;
            else if (m_q0.size() != 0) m_pick = 0;
            if (m_q1.size() == 0 || m_pick == 1) m_starve = 0;
            else m_starve = m_starve + 1;
            m_wen = (m_pick >= 0);
            if (m_pick == 0) m_w = m_q0.pop_front();
            if (m_pick == 1) m_w = m_q1.pop_front();
            if (m_pick >= 0) begin
                m_waddr = m_w.addr;
                m_wdata = m_w.data;
            end
            if (m_acc0 && s0_addr != 5'd0) m_q0.push_back({s0_addr, s0_data});
            if (m_acc1 && s1_addr != 5'd0) m_q1.push_back({s1_addr, s1_data});
            m_live = 1'b1;
        end
    end

    // Compare process and write monitor, sampled on the falling edge.
    initial forever begin
        logic [31:0] em;
        @(negedge clk);
        if (rf_wen === 1'b1) got_q.push_back({rf_waddr, rf_wdata});
        if (check_en) begin
            em = '0;
            foreach (m_q0[i]) em[m_q0[i].addr] = 1'b1;
            foreach (m_q1[i]) em[m_q1[i].addr] = 1'b1;
            if (m_wen) em[m_waddr] = 1'b1;
            chk("model_rf_wen", {31'd0, rf_wen}, {31'd0, m_wen});
            chk("model_rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
            chk("model_rf_wdata", rf_wdata, m_wdata);
            chk("model_pend_mask", pend_mask, em);
            chk("model_busy", {31'd0, busy}, {31'd0, (em != 0)});
            chk("model_s0_rdy", {31'd0, s0_rdy}, {31'd0, (m_live && m_q0.size() < DEPTH)});
            chk("model_s1_rdy", {31'd0, s1_rdy}, {31'd0, (m_live && m_q1.size() < DEPTH)});
        end
    end

    task automatic send0(input logic [4:0] a, input logic [31:0] d, output int waits);
        s0_val  = 1'b1;
        s0_addr = a;
        s0_data = d;
        waits   = 0;
        while (s0_rdy !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        if (waits >= 50) chk("s0_accept_timeout", {31'd0, s0_rdy}, 32'd1);
        tick();
    endtask

    task automatic send1(input logic [4:0] a, input logic [31:0] d, output int waits);
        s1_val  = 1'b1;
        s1_addr = a;
        s1_data = d;
        waits   = 0;
        while (s1_rdy !== 1'b1 && waits < 50) begin
            tick();
            waits++;
        end
        if (waits >= 50) chk("s1_accept_timeout", {31'd0, s1_rdy}, 32'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp_writes(input string name, input logic [36:0] got[$], input logic [36:0] exp[$]);
        logic [36:0] g;
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : '0;
            chk({name, "_addr"}, {27'd0, g[36:32]}, {27'd0, exp[i][36:32]});
            chk({name, "_data"}, g[31:0], exp[i][31:0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w0, w1, w9;
        int          order5[9];
        logic [36:0] flt[$];

        reset   = 1'b1;
        domain  = 1'b0;
        s0_val  = 1'b0; s0_addr = '0; s0_data = '0;
        s1_val  = 1'b0; s1_addr = '0; s1_data = '0;
        #2 reset = 1'b0;
        tick();
        check_en = 1'b1;
        tick();

        // Reset state and release
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_pend_mask", pend_mask, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_s0_rdy", {31'd0, s0_rdy}, 32'd0);
        chk("rst_s1_rdy", {31'd0, s1_rdy}, 32'd0);
        reset = 1'b1;
        #1;
        chk("release_s0_rdy_same_cycle", {31'd0, s0_rdy}, 32'd0);
        tick();
        chk("release_s0_rdy", {31'd0, s0_rdy}, 32'd1);
        chk("release_s1_rdy", {31'd0, s1_rdy}, 32'd1);

        // Single write
        got_q.delete();
        s0_val = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
        tick();
        s0_val = 1'b0;
        chk("single_mask_after_accept", pend_mask, 32'h0000_0020);
        chk("single_wen_early", {31'd0, rf_wen}, 32'd0);
        tick();
        chk("single_wen", {31'd0, rf_wen}, 32'd1);
        chk("single_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_mask_during_write", pend_mask, 32'h0000_0020);
        tick();
        chk("single_wen_done", {31'd0, rf_wen}, 32'd0);
        chk("single_mask_clear", pend_mask, 32'd0);
        chk("single_waddr_hold", {27'd0, rf_waddr}, 32'd5);

        // r0 drop
        chk("r0_s1_rdy", {31'd0, s1_rdy}, 32'd1);
        s1_val = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
        tick();
        s1_val = 1'b0;
        chk("r0_mask", pend_mask, 32'd0);
        repeat (3) begin
            tick();
            chk("r0_mask_later", pend_mask, 32'd0);
        end
        chk("r0_no_write", got_q.size(), 32'd1);

        // Backpressure on s1 while s0 streams
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send0(5'(10 + i), 32'h100 + i, w0);
                s0_val = 1'b0;
            end
            begin
                send1(5'd7, 32'hA000_0007, w1);
                send1(5'd8, 32'hA000_0008, w1);
                chk("bp_s1_full", {31'd0, s1_rdy}, 32'd0);
                send1(5'd9, 32'hA000_0009, w9);
                s1_val = 1'b0;
                chk("bp_r9_wait", w9, 32'd4);
            end
        join
        drain();
        flt.delete();
        foreach (got_q[i]) if (got_q[i][36:32] < 5'd10) flt.push_back(got_q[i]);
        exp_q.delete();
        exp_q.push_back({5'd7, 32'hA000_0007});
        exp_q.push_back({5'd8, 32'hA000_0008});
        exp_q.push_back({5'd9, 32'hA000_0009});
        cmp_writes("bp_s1_order", flt, exp_q);
        chk("bp_total_writes", got_q.size(), 32'd11);

        // Starvation: s1 forced through on the fifth contended cycle
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send0(5'(20 + i), 32'h200 + i, w0);
                s0_val = 1'b0;
            end
            begin
                send1(5'd3, 32'h3333_0003, w1);
                s1_val = 1'b0;
            end
        join
        drain();
        order5 = '{20, 21, 22, 23, 3, 24, 25, 26, 27};
        exp_q.delete();
        foreach (order5[i]) begin
            if (order5[i] == 3) exp_q.push_back({5'd3, 32'h3333_0003});
            else exp_q.push_back({5'(order5[i]), 32'h200 + 32'(order5[i] - 20)});
        end
        cmp_writes("starve_order", got_q, exp_q);

        // Reset mid-operation
        s0_val = 1'b1; s0_addr = 5'd11; s0_data = 32'hB11;
        s1_val = 1'b1; s1_addr = 5'd12; s1_data = 32'hB12;
        tick();
        s0_addr = 5'd13; s0_data = 32'hB13;
        s1_addr = 5'd14; s1_data = 32'hB14;
        tick();
        s0_val = 1'b0;
        s1_val = 1'b0;
        chk("midrst_wen_before", {31'd0, rf_wen}, 32'd1);
        chk("midrst_mask_before", pend_mask, 32'h0000_7800);
        reset = 1'b0;
        #1;
        chk("midrst_wen_async", {31'd0, rf_wen}, 32'd0);
        chk("midrst_mask_async", pend_mask, 32'd0);
        chk("midrst_busy_async", {31'd0, busy}, 32'd0);
        chk("midrst_s0_rdy_async", {31'd0, s0_rdy}, 32'd0);
        got_q.delete();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("midrst_no_stale_write", got_q.size(), 32'd0);
        chk("midrst_mask_after", pend_mask, 32'd0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
